ex_issue_ctrl: RTL and testbench

//  Issue controller between decode and ALU (execute) stage of the RV32I pipeline.

---
 rtl/ex_issue_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl
//   Issue controller between the decode and execute stages of the RV32I pipeline.
//   Decoded instructions enter through a valid/ready handshake into a 2-entry FIFO.
//   The FIFO head drives the ALU inputs directly. One bubble is inserted when the
//   instruction about to issue reads the destination of a load issued in the
//   previous cycle. A flush kills all queued work for one cycle. Bubble and flush
//   events are counted with saturating counters.
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   id_valid / id_ready         decode handshake
//   id_payload, id_rd, id_rs1,  decoded instruction bundle and register fields
//   id_rs2, id_use_rs1,
//   id_use_rs2, id_is_load
//   ex_valid / ex_ready         execute handshake
//   ex_payload, ex_rd,          issued instruction (FIFO head)
//   ex_is_load
//   flush                       branch redirect: discard everything queued
//   bubble_cnt, flush_cnt       saturating event counters
module ex_issue_ctrl #(
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [PAYLOAD_W-1:0] id_payload,
    input  logic [4:0]           id_rd,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 id_is_load,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [PAYLOAD_W-1:0] ex_payload,
    output logic [4:0]           ex_rd,
    output logic                 ex_is_load,
    input  logic                 flush,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic                 use_rs1;
        logic                 use_rs2;
        logic                 is_load;
    } entry_t;

    // The load-use bubble is the hazard cycle itself (see ex_valid), so the
    // registered FSM only needs to distinguish normal issue from the kill cycle.
    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

    state_e            state_q, state_d;
    entry_t            mem_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [4:0]        load_rd_q;
    logic              load_vld_q;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    entry_t            id_entry;
    entry_t            head;
    logic              run;
    logic              cand_vld;
    logic [4:0]        cand_rs1, cand_rs2;
    logic              cand_use_rs1, cand_use_rs2;
    logic              hazard;
    logic              bubble;
    logic              push, pop;
    logic              pop_load;

    always_comb begin
        id_entry         = '0;
        id_entry.payload = id_payload;
        id_entry.rd      = id_rd;
        id_entry.rs1     = id_rs1;
        id_entry.rs2     = id_rs2;
        id_entry.use_rs1 = id_use_rs1;
        id_entry.use_rs2 = id_use_rs2;
        id_entry.is_load = id_is_load;
    end

    assign head = mem_q[rd_ptr_q];
    assign run  = (state_q == StRun);

    // The instruction that would issue next: queue head, or the one on the
    // decode port when the queue is empty (it would flow straight through).
    always_comb begin
        cand_vld     = 1'b0;
        cand_rs1     = '0;
        cand_rs2     = '0;
        cand_use_rs1 = 1'b0;
        cand_use_rs2 = 1'b0;
        if (count_q != 2'd0) begin
            cand_vld     = 1'b1;
            cand_rs1     = head.rs1;
            cand_rs2     = head.rs2;
            cand_use_rs1 = head.use_rs1;
            cand_use_rs2 = head.use_rs2;
        end else begin
            cand_vld     = id_valid;
            cand_rs1     = id_rs1;
            cand_rs2     = id_rs2;
            cand_use_rs1 = id_use_rs1;
            cand_use_rs2 = id_use_rs2;
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (cand_vld && load_vld_q) begin
            hazard = (cand_use_rs1 && (cand_rs1 != 5'd0) && (cand_rs1 == load_rd_q)) ||
                     (cand_use_rs2 && (cand_rs2 != 5'd0) && (cand_rs2 == load_rd_q));
        end
    end

    // Flush outranks the hazard: a bubble is only charged when no kill happens.
    assign bubble   = run && hazard && !flush;

    assign ex_valid = (count_q != 2'd0) && run && !hazard;
    // rst_n gates id_ready so decode never sees ready while reset is held.
    assign id_ready = rst_n && (count_q != 2'd2) && run && !flush && !hazard;

    assign push     = id_valid && id_ready;
    assign pop      = ex_valid && ex_ready;
    assign pop_load = pop && head.is_load && (head.rd != 5'd0);

    assign ex_payload = head.payload;
    assign ex_rd      = head.rd;
    assign ex_is_load = head.is_load;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   state_d = flush ? StFlush : StRun;
            StFlush: state_d = flush ? StFlush : StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            load_rd_q    <= 5'd0;
            load_vld_q   <= 1'b0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            // load_vld is a one-cycle pulse after a load with rd!=0 issues.
            load_vld_q   <= pop_load && !flush;
            if (pop_load) begin
                load_rd_q <= head.rd;
            end
            if (flush) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= id_entry;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: a hand-derived vector table for the main scenarios,
// a hand-written asynchronous-reset sequence, and a randomized run against a
// queue-based reference model. Counters use a narrow width so saturation is hit.
module tb_ex_issue_ctrl;

    localparam int unsigned PW     = 64;
    localparam int unsigned CW     = 4;
    localparam int          CntMax = (1 << CW) - 1;
    localparam logic        Y      = 1'b1;
    localparam logic        N      = 1'b0;

    logic           clk;
    logic           rst_n;
    logic           id_valid;
    logic           id_ready;
    logic [PW-1:0]  id_payload;
    logic [4:0]     id_rd;
    logic [4:0]     id_rs1;
    logic [4:0]     id_rs2;
    logic           id_use_rs1;
    logic           id_use_rs2;
    logic           id_is_load;
    logic           ex_valid;
    logic           ex_ready;
    logic [PW-1:0]  ex_payload;
    logic [4:0]     ex_rd;
    logic           ex_is_load;
    logic           flush;
    logic [CW-1:0]  bubble_cnt;
    logic [CW-1:0]  flush_cnt;

    int checks = 0;
    int errors = 0;

    ex_issue_ctrl #(
        .PAYLOAD_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_payload (id_payload),
        .id_rd      (id_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_is_load (id_is_load),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_payload (ex_payload),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .flush      (flush),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] payload;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_rs1;
        logic        use_rs2;
        logic        is_load;
    } instr_t;

    typedef struct packed {
        logic        v;
        instr_t      i;
        logic        er;
        logic        fl;
        logic        e_rdy;
        logic        e_vld;
        logic [63:0] e_pl;
        logic [3:0]  e_bc;
        logic [3:0]  e_fc;
    } vec_t;

    vec_t tbl[$];

    function automatic instr_t mi(input logic [63:0] pl, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2, input logic ld);
        instr_t r;
        r.payload = pl;
        r.rd      = rd;
        r.rs1     = rs1;
        r.rs2     = rs2;
        r.use_rs1 = u1;
        r.use_rs2 = u2;
        r.is_load = ld;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic v, input instr_t i, input logic er, input logic fl);
        id_valid   = v;
        id_payload = i.payload;
        id_rd      = i.rd;
        id_rs1     = i.rs1;
        id_rs2     = i.rs2;
        id_use_rs1 = i.use_rs1;
        id_use_rs2 = i.use_rs2;
        id_is_load = i.is_load;
        ex_ready   = er;
        flush      = fl;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " id_ready"}, 64'(id_ready), 64'd0);
        chk({tag, " ex_valid"}, 64'(ex_valid), 64'd0);
        chk({tag, " ex_payload"}, ex_payload, 64'd0);
        chk({tag, " ex_rd"}, 64'(ex_rd), 64'd0);
        chk({tag, " ex_is_load"}, 64'(ex_is_load), 64'd0);
        chk({tag, " bubble_cnt"}, 64'(bubble_cnt), 64'd0);
        chk({tag, " flush_cnt"}, 64'(flush_cnt), 64'd0);
    endtask

    // Reference model: a plain queue of instructions plus "what issued last cycle".
    instr_t      mq[$];
    logic        ll_vld;
    logic [4:0]  ll_rd;
    logic        aft_fl;
    int          m_bc;
    int          m_fc;

    task automatic rand_cycle(input int cyc);
        instr_t in;
        instr_t c;
        logic   v, er, fl, cv, dep, e_vld, e_rdy;
        string  t;
        in.payload = {$urandom, $urandom};
        in.rd      = 5'($urandom_range(0, 3));
        in.rs1     = 5'($urandom_range(0, 3));
        in.rs2     = 5'($urandom_range(0, 3));
        in.use_rs1 = 1'($urandom_range(0, 1));
        in.use_rs2 = 1'($urandom_range(0, 1));
        in.is_load = ($urandom_range(0, 99) < 35);
        v  = ($urandom_range(0, 99) < 70);
        er = ($urandom_range(0, 99) < 75);
        fl = ($urandom_range(0, 99) < 4);
        apply(v, in, er, fl);
        @(negedge clk);
        if (mq.size() != 0) begin
            c  = mq[0];
            cv = 1'b1;
        end else begin
            c  = in;
            cv = v;
        end
        dep = cv && ll_vld &&
              ((c.use_rs1 && c.rs1 != 5'd0 && c.rs1 == ll_rd) ||
               (c.use_rs2 && c.rs2 != 5'd0 && c.rs2 == ll_rd));
        e_vld = (mq.size() != 0) && !aft_fl && !dep;
        e_rdy = (mq.size() < 2) && !aft_fl && !fl && !dep;
        t = $sformatf("rnd%0d", cyc);
        chk({t, " id_ready"}, 64'(id_ready), 64'(e_rdy));
        chk({t, " ex_valid"}, 64'(ex_valid), 64'(e_vld));
        if (e_vld) begin
            chk({t, " ex_payload"}, ex_payload, mq[0].payload);
            chk({t, " ex_rd"}, 64'(ex_rd), 64'(mq[0].rd));
            chk({t, " ex_is_load"}, 64'(ex_is_load), 64'(mq[0].is_load));
        end
        chk({t, " bubble_cnt"}, 64'(bubble_cnt), 64'(m_bc));
        chk({t, " flush_cnt"}, 64'(flush_cnt), 64'(m_fc));
        if (fl) begin
            mq.delete();
            ll_vld = 1'b0;
            aft_fl = 1'b1;
            if (m_fc < CntMax) m_fc++;
        end else begin
            if (dep && !aft_fl && m_bc < CntMax) m_bc++;
            if (e_vld && er) begin
                ll_vld = mq[0].is_load && (mq[0].rd != 5'd0);
                ll_rd  = mq[0].rd;
                void'(mq.pop_front());
            end else begin
                ll_vld = 1'b0;
            end
            if (v && e_rdy) mq.push_back(in);
            aft_fl = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        instr_t nop;
        nop = '0;

        // Directed vectors: {id_valid, instr, ex_ready, flush, exp id_ready, exp ex_valid,
        // exp ex_payload (when valid), exp bubble_cnt, exp flush_cnt}, sampled before the edge.
        // Back-to-back independent instructions.
        tbl.push_back('{N, nop, Y, N, Y, N, 64'h0, 4'd0, 4'd0});
        tbl.push_back('{Y, mi(64'h11, 5'd1, 5'd0, 5'd0, N, N, N), Y, N, Y, N, 64'h0, 4'd0, 4'd0});
        tbl.push_back('{Y, mi(64'h22, 5'd2, 5'd1, 5'd0, N, N, N), Y, N, Y, Y, 64'h11, 4'd0, 4'd0});
        tbl.push_back('{Y, mi(64'h33, 5'd3, 5'd2, 5'd0, N, N, N), Y, N, Y, Y, 64'h22, 4'd0, 4'd0});
        tbl.push_back('{N, nop, Y, N, Y, Y, 64'h33, 4'd0, 4'd0});
        tbl.push_back('{N, nop, Y, N, Y, N, 64'h0, 4'd0, 4'd0});
        // LOAD x5 then ADD reading x5: one bubble.
        tbl.push_back('{Y, mi(64'h44, 5'd5, 5'd0, 5'd0, N, N, Y), Y, N, Y, N, 64'h0, 4'd0, 4'd0});
        tbl.push_back('{Y, mi(64'h55, 5'd6, 5'd5, 5'd0, Y, N, N), Y, N, Y, Y, 64'h44, 4'd0, 4'd0});
        tbl.push_back('{N, nop, Y, N, N, N, 64'h0, 4'd0, 4'd0});
        tbl.push_back('{N, nop, Y, N, Y, Y, 64'h55, 4'd1, 4'd0});
        // LOAD x0 then ADD reading x0: no bubble.
        tbl.push_back('{Y, mi(64'h66, 5'd0, 5'd0, 5'd0, N, N, Y), Y, N, Y, N, 64'h0, 4'd1, 4'd0});
        tbl.push_back('{Y, mi(64'h77, 5'd6, 5'd0, 5'd0, Y, N, N), Y, N, Y, Y, 64'h66, 4'd1, 4'd0});
        tbl.push_back('{N, nop, Y, N, Y, Y, 64'h77, 4'd1, 4'd0});
        tbl.push_back('{N, nop, Y, N, Y, N, 64'h0, 4'd1, 4'd0});
        // Back-pressure for four cycles: queue fills, head held, then drains in order.
        tbl.push_back('{Y, mi(64'h81, 5'd1, 5'd0, 5'd0, N, N, N), N, N, Y, N, 64'h0, 4'd1, 4'd0});
        tbl.push_back('{Y, mi(64'h82, 5'd2, 5'd0, 5'd0, N, N, N), N, N, Y, Y, 64'h81, 4'd1, 4'd0});
        tbl.push_back('{Y, mi(64'h83, 5'd3, 5'd0, 5'd0, N, N, N), N, N, N, Y, 64'h81, 4'd1, 4'd0});
        tbl.push_back('{Y, mi(64'h83, 5'd3, 5'd0, 5'd0, N, N, N), N, N, N, Y, 64'h81, 4'd1, 4'd0});
        tbl.push_back('{N, nop, Y, N, N, Y, 64'h81, 4'd1, 4'd0});
        tbl.push_back('{N, nop, Y, N, Y, Y, 64'h82, 4'd1, 4'd0});
        tbl.push_back('{N, nop, Y, N, Y, N, 64'h0, 4'd1, 4'd0});
        // Flush with two queued; the instruction offered during flush is dropped.
        tbl.push_back('{Y, mi(64'h91, 5'd1, 5'd0, 5'd0, N, N, N), N, N, Y, N, 64'h0, 4'd1, 4'd0});
        tbl.push_back('{Y, mi(64'h92, 5'd2, 5'd0, 5'd0, N, N, N), N, N, Y, Y, 64'h91, 4'd1, 4'd0});
        tbl.push_back('{Y, mi(64'h93, 5'd3, 5'd0, 5'd0, N, N, N), N, Y, N, Y, 64'h91, 4'd1, 4'd0});
        tbl.push_back('{N, nop, Y, N, N, N, 64'h0, 4'd1, 4'd1});
        tbl.push_back('{N, nop, Y, N, Y, N, 64'h0, 4'd1, 4'd1});
        // Flush in the same cycle as a load-use hazard: no bubble charged, hazard gone.
        tbl.push_back('{Y, mi(64'ha1, 5'd7, 5'd0, 5'd0, N, N, Y), Y, N, Y, N, 64'h0, 4'd1, 4'd1});
        tbl.push_back('{Y, mi(64'ha2, 5'd8, 5'd0, 5'd7, N, Y, N), Y, N, Y, Y, 64'ha1, 4'd1, 4'd1});
        tbl.push_back('{N, nop, Y, Y, N, N, 64'h0, 4'd1, 4'd1});
        tbl.push_back('{N, nop, Y, N, N, N, 64'h0, 4'd1, 4'd2});
        tbl.push_back('{Y, mi(64'hb1, 5'd9, 5'd7, 5'd0, Y, N, N), Y, N, Y, N, 64'h0, 4'd1, 4'd2});
        tbl.push_back('{N, nop, Y, N, Y, Y, 64'hb1, 4'd1, 4'd2});
        tbl.push_back('{N, nop, Y, N, Y, N, 64'h0, 4'd1, 4'd2});

        rst_n = 1'b0;
        apply(N, nop, N, N);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            apply(tbl[k].v, tbl[k].i, tbl[k].er, tbl[k].fl);
            @(negedge clk);
            chk($sformatf("row%0d id_ready", k), 64'(id_ready), 64'(tbl[k].e_rdy));
            chk($sformatf("row%0d ex_valid", k), 64'(ex_valid), 64'(tbl[k].e_vld));
            if (tbl[k].e_vld) begin
                chk($sformatf("row%0d ex_payload", k), ex_payload, tbl[k].e_pl);
            end
            chk($sformatf("row%0d bubble_cnt", k), 64'(bubble_cnt), 64'(tbl[k].e_bc));
            chk($sformatf("row%0d flush_cnt", k), 64'(flush_cnt), 64'(tbl[k].e_fc));
            @(posedge clk);
            #1;
        end

        // Reset pulsed mid-stream with a full queue.
        apply(Y, mi(64'hc1, 5'd4, 5'd0, 5'd0, N, N, Y), N, N);
        @(posedge clk);
        #1;
        apply(Y, mi(64'hc2, 5'd5, 5'd0, 5'd0, N, N, N), N, N);
        @(posedge clk);
        #1;
        apply(N, nop, N, N);
        #2;
        chk("full id_ready", 64'(id_ready), 64'd0);
        chk("full ex_valid", 64'(ex_valid), 64'd1);
        chk("full ex_payload", ex_payload, 64'hc1);
        chk("full ex_rd", 64'(ex_rd), 64'd4);
        chk("full ex_is_load", 64'(ex_is_load), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        @(posedge clk);
        #1;
        chk_reset_outs("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst id_ready", 64'(id_ready), 64'd1);
        chk("post_rst ex_valid", 64'(ex_valid), 64'd0);
        @(posedge clk);
        #1;

        // Randomized run against the reference model.
        ll_vld = 1'b0;
        ll_rd  = 5'd0;
        aft_fl = 1'b0;
        m_bc   = 0;
        m_fc   = 0;
        for (int n = 0; n < 2000; n++) begin
            rand_cycle(n);
        end
        chk("rnd flush_cnt saturated", 64'(flush_cnt), 64'(CntMax));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
